disp_scan_arbiter: RTL
======================

DISP_SCAN_ARBITER -- requirements
Module: disp_scan_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DIV, 1000, clock cycles per digit scan slot; legal range is at least 4.
- BLANK, 16, blanking cycles at the start of each slot; legal range is 1 to DIV-2.
REQ-002 Ports, one per line: name, direction, width, meaning.
- cin, in, 1, the only clock; all logic is on the rising edge.
- rst, in, 1, synchronous reset, active-high.
- req_a, in, 1, write request from requester A (core).
- dig_a, in, 2, target digit for A.
- dat_a, in, 6, data for A: {blank, dp, hex[3:0]}.
- ack_a, out, 1, one-cycle write-accepted pulse to A.
- req_b, in, 1, write request from requester B (debug).
- dig_b, in, 2, target digit for B.
- dat_b, in, 6, data for B, same format as dat_a.
- ack_b, out, 1, one-cycle write-accepted pulse to B.
- seg, out, 8, segment drive, active-low: seg[0]=a through seg[6]=g, seg[7]=dp.
- en, out, 3, digit enable, active-low: en[i] selects digit i.
- frame_tick, out, 1, one-cycle pulse at each scan wrap.

Function
REQ-003 The prescaler shall count 0..DIV-1 and wrap to 0; digit index shall advance 0->1->2->0 on the cycle the prescaler equals DIV-1.
REQ-004 While the prescaler is below BLANK, en shall be 3'b111 and seg 8'hFF; otherwise en shall have only bit[index] low and seg shall be the decode of the displayed register for index.
REQ-005 Decode: blank=1 gives 8'hFF; otherwise segments a–g follow standard hex 0–F glyphs (active-low) and seg[7]=~dp.
REQ-006 Writes shall go to a 3-entry shadow register file; the display register file shall load all 3 shadow entries in the same cycle the index wraps from 2 to 0, with no tearing mid-frame.
REQ-007 frame_tick shall be asserted in exactly that load cycle, once per 3*DIV cycles.
REQ-008 Handshake: a requester holds req, dig and dat stable until ack; ack shall be a registered pulse, the shadow write shall occur on the ack cycle, and the requester may drop req or present a new request on the next cycle.
REQ-009 At most one grant per cycle; after an ack the granted side shall not be granted in the following cycle, giving a 2-cycle minimum per requester.
REQ-010 If req_a and req_b are both pending, arbitration shall be round-robin; the priority pointer starts at A and moves to the non-granted side after each grant.
REQ-011 A request with dig=3 shall be acked but shall not modify any register.
REQ-012 Write versus load collision: a write acked in the load cycle shall update the shadow only; the display shall reflect it at the next wrap.
REQ-013 Latency from ack to visible output shall be at most one frame plus one cycle.

Reset
REQ-014 On rst=1 at a clock edge: prescaler=0, index=0, all shadow and display entries=6'b100000, pointer=A, ack_a=ack_b=0, frame_tick=0, en=3'b111, seg=8'hFF.
REQ-015 rst shall override any pending or in-flight request; no ack shall be issued in the reset cycle or for requests held across reset, until they are re-arbitrated after rst falls.

Structure
REQ-016 A shared package shall hold the data field positions (BLANK_BIT=5, DP_BIT=4, HEX msb/lsb), the reset data constant 6'b100000, and the blank segment constant 8'hFF.
REQ-017 Hex-to-segment decode shall be one combinational sub-module, hex7seg, instantiated once on the selected display entry.

Verification (DIV=8, BLANK=2)
REQ-018 Reset then idle 48 cycles: en is 111 at prescaler 0–1, and 110/101/011 at prescaler 2–7 of slots 0/1/2; seg=FF throughout; frame_tick every 24 cycles.
REQ-019 A writes dig=1 dat=6'b000101: ack_a pulses 1 cycle; at the next wrap, during slot 1 active cycles, en=101 and seg=8'h92.
REQ-020 req_a and req_b held together continuously: acks alternate A,B,A,B with a gap so neither side is acked in consecutive cycles.
REQ-021 B writes dig=3: ack_b pulses; the display is unchanged after the next two frames.
REQ-022 A write acked in the frame_tick cycle (dig=0 dat=6'b010000): digit 0 shows seg=8'h40 only after the following frame_tick.
REQ-023 Assert rst mid-frame with req_a high: outputs return to REQ-014 values next cycle, and ack_a arrives only after rst deasserts.

Source files
------------

// File: rtl/disp_scan_arbiter_pkg.sv
// Shared field layout and constants for the multiplexed display scanner
// and its two-requester write arbiter.
package disp_scan_arbiter_pkg;

    localparam int BLANK_BIT = 5;
    localparam int DP_BIT    = 4;
    localparam int HEX_MSB   = 3;
    localparam int HEX_LSB   = 0;

    localparam logic [5:0] RST_DATA  = 6'b100000;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef logic [5:0] disp_data_t;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } rr_ptr_t;

endpackage

// File: rtl/disp_scan_arbiter_hex7seg.sv
// Hex digit to active-low seven-segment pattern, with blank and
// decimal-point control taken from the packed display data word.
module hex7seg
    import disp_scan_arbiter_pkg::*;
(
    input  logic [5:0] dat,
    output logic [7:0] seg
);

    logic [6:0] glyph;

    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch can be inferred.
        glyph = 7'h7F;
        seg   = SEG_BLANK;
        case (dat[HEX_MSB:HEX_LSB])
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        if (!dat[BLANK_BIT]) begin
            seg = {~dat[DP_BIT], glyph};
        end
    end

endmodule

// File: rtl/disp_scan_arbiter.sv
// Three-digit scanned display with shadow/display register files, a
// frame-synchronous shadow-to-display load and a round-robin write arbiter.
module disp_scan_arbiter
    import disp_scan_arbiter_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic       cin,
    input  logic       rst,
    input  logic       req_a,
    input  logic [1:0] dig_a,
    input  logic [5:0] dat_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [1:0] dig_b,
    input  logic [5:0] dat_b,
    output logic       ack_b,
    output logic [7:0] seg,
    output logic [2:0] en,
    output logic       frame_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    disp_data_t       shadow [3];
    disp_data_t       disp   [3];
    rr_ptr_t          ptr;

    logic       elig_a, elig_b, grant_a, grant_b, wr_en;
    logic [1:0] wr_dig;
    disp_data_t wr_dat, sel_dat;
    logic [7:0] seg_dec;

    // A side that was acked last cycle still has its request up, so it sits out one cycle.
    assign elig_a  = req_a && !ack_a;
    assign elig_b  = req_b && !ack_b;
    assign grant_a = elig_a && (!elig_b || ptr == PTR_A);
    assign grant_b = elig_b && !grant_a;
    assign wr_dig  = grant_b ? dig_b : dig_a;
    assign wr_dat  = grant_b ? dat_b : dat_a;
    assign wr_en   = (grant_a || grant_b) && (wr_dig != 2'd3);

    always_ff @(posedge cin) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            ptr        <= PTR_A;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            frame_tick <= 1'b0;
            // NOTE: these register files are a handful of flops, not RAM, so they are reset to blank.
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= RST_DATA;
                disp[i]   <= RST_DATA;
            end
        end else begin
            // NOTE: non-blocking assignments here, so disp loads the pre-write shadow in a collision cycle.
            ack_a      <= grant_a;
            ack_b      <= grant_b;
            frame_tick <= 1'b0;
            if (grant_a) begin
                ptr <= PTR_B;
            end else if (grant_b) begin
                ptr <= PTR_A;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (idx == 2'd2) begin
                    idx        <= 2'd0;
                    frame_tick <= 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        disp[i] <= shadow[i];
                    end
                end else begin
                    idx <= idx + 2'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (wr_en && wr_dig == 2'(i)) begin
                    shadow[i] <= wr_dat;
                end
            end
        end
    end

    always_comb begin
        sel_dat = disp[0];
        case (idx)
            2'd1:    sel_dat = disp[1];
            2'd2:    sel_dat = disp[2];
            default: sel_dat = disp[0];
        endcase
    end

    hex7seg u_hex7seg (
        .dat (sel_dat),
        .seg (seg_dec)
    );

    always_comb begin
        en  = 3'b111;
        seg = SEG_BLANK;
        if (cnt >= CNT_BLANK) begin
            en  = ~(3'b001 << idx);
            seg = seg_dec;
        end
    end

endmodule
